ifmap_window_buffer: RTL and testbench

Parametrised successor to the single-lane IFMap buffer inside the Conv datapath. It accepts PAR_IN row-tagged IFMap words per cycle into a circular store. It presents a sliding window of filter_size words, read by random offset, to the PE. The window advances by a programmable stride and jumps cleanly across row boundaries using the start-of-row/end-of-row tags.

---
 rtl/ifmap_window_buffer.sv | 202 ++++++++++++++++++++
 tb/tb_ifmap_window_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifmap_window_buffer.sv
// ifmap_window_buffer
//   Circular IFMap store. Each write beat carries PAR_IN row-tagged words.
//   The PE reads a sliding window of filter_size words at a random offset.
//   The window advances by a programmable stride. When the end-of-row tag
//   falls inside the window's stride span, the window jumps straight to
//   the first word of the next row.
//
// Optional feature (define the macro IFBUF_TAG_CHECK_EN to enable):
//   Adds a write-side tag checker that raises a sticky tag_err on
//   malformed SOR/EOR sequences. Without the macro, tag_err is tied low.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clr               synchronous clear of pointers, count and read/tag state
//   wen, wdata        write request; lane i is wdata[i*(DATA_WIDTH+2) +: DATA_WIDTH+2]
//                     and is laid out as {SOR, EOR, data}
//   ready             free space >= PAR_IN
//   stride            window step in words (0 acts as 1)
//   filter_size       window length in words (0 means no window)
//   rd_en, rd_offset  window read request and offset from the window base
//   rd_data, rd_valid registered read data and its one-cycle valid pulse
//   advance           release the window and move the base
//   win_valid         the current window is usable
//   row_last          the current window is the last one of its row
//   count             number of words stored from the base onward
//   tag_err           sticky tag error
module ifmap_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int PAR_IN     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr,
  input  logic                             wen,
  input  logic [PAR_IN*(DATA_WIDTH+2)-1:0] wdata,
  output logic                             ready,
  input  logic [ADDR_WIDTH-1:0]            stride,
  input  logic [ADDR_WIDTH-1:0]            filter_size,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_offset,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  input  logic                             advance,
  output logic                             win_valid,
  output logic                             row_last,
  output logic [ADDR_WIDTH:0]              count,
  output logic                             tag_err
);

  localparam int W  = DATA_WIDTH + 2;  // stored word: {SOR, EOR, data}
  localparam int CW = ADDR_WIDTH + 1;  // count width, holds 0..DEPTH
  localparam int PW = ADDR_WIDTH + 2;  // scan position width, holds filter_size+stride

  logic [W-1:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;

  logic [ADDR_WIDTH-1:0]   stride_eff;
  logic                    eor_found;
  logic [PW-1:0]           eor_pos;
  logic [PW-1:0]           fs_w, cnt_w, full_thr, release_len;
  logic                    wr_acc, do_adv;
  logic [ADDR_WIDTH-1:0]   rd_addr;

  assign stride_eff = (stride == '0) ? ADDR_WIDTH'(1) : stride;
  assign ready      = (count_q <= CW'(DEPTH - PAR_IN));
  assign wr_acc     = wen && ready;

  // Scan positions filter_size-1 .. filter_size+stride-2 (relative to base).
  // The first EOR in that span marks the row end. Only positions already
  // written (p < count) are considered.
  // NOTE: every variable driven by an always_comb block gets a default
  // before any conditional logic, so no latch can be inferred.
  always_comb begin
    eor_found = 1'b0;
    eor_pos   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0]         p;
      logic [ADDR_WIDTH-1:0] a;
      p = PW'(filter_size) - PW'(1) + PW'(k);
      a = base_q + ADDR_WIDTH'(p);
      if (!eor_found && (filter_size != '0) && (PW'(k) < PW'(stride_eff)) &&
          (p < PW'(count_q)) && mem_q[a][W-2]) begin
        eor_found = 1'b1;
        eor_pos   = p;
      end
    end
  end

  assign fs_w      = PW'(filter_size);
  assign cnt_w     = PW'(count_q);
  assign full_thr  = fs_w + PW'(stride_eff) - PW'(1);
  assign win_valid = (filter_size != '0) && (cnt_w >= fs_w) &&
                     ((cnt_w >= full_thr) || eor_found);
  assign row_last  = eor_found && win_valid;
  assign do_adv    = advance && win_valid;

  // A row-end window releases everything up to and including the EOR word.
  // Any other window releases one stride.
  assign release_len = row_last ? (eor_pos + PW'(1)) : PW'(stride_eff);
  assign rd_addr     = base_q + rd_offset;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    base_d     = base_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    if (clr) begin
      wr_ptr_d = '0;
      base_d   = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(PAR_IN);
      if (do_adv) base_d = base_q + ADDR_WIDTH'(release_len);
      count_d = count_q + (wr_acc ? CW'(PAR_IN) : CW'(0))
                        - (do_adv ? CW'(release_len) : CW'(0));
      // The read always uses the pre-advance base.
      if (rd_en && win_valid) begin
        rd_valid_d = 1'b1;
        rd_data_d  = (rd_offset >= filter_size) ? '0 : mem_q[rd_addr][DATA_WIDTH-1:0];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop in
  // this file samples its next value at the same instant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      base_q     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      base_q     <= base_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // NOTE: the storage array has no reset. Nothing reads a word until it
  // has been written, because count gates every access.
  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      for (int i = 0; i < PAR_IN; i++) begin
        mem_q[wr_ptr_q + ADDR_WIDTH'(i)] <= wdata[i*W +: W];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;

`ifdef IFBUF_TAG_CHECK_EN
  typedef enum logic {EXPECT_SOR, IN_ROW} tag_state_e;

  tag_state_e tag_state_q, tag_state_d;
  logic       tag_err_q, tag_err_d;

  // Walk the accepted lanes in order. Each lane sees the state left by the
  // previous lane. A word carrying both tags is a complete one-word row.
  always_comb begin
    tag_state_d = tag_state_q;
    tag_err_d   = tag_err_q;
    if (clr) begin
      tag_state_d = EXPECT_SOR;
      tag_err_d   = 1'b0;
    end else if (wr_acc) begin
      for (int i = 0; i < PAR_IN; i++) begin
        if ((tag_state_d == EXPECT_SOR) && !wdata[i*W + W-1]) tag_err_d = 1'b1;
        if ((tag_state_d == IN_ROW)     &&  wdata[i*W + W-1]) tag_err_d = 1'b1;
        if (wdata[i*W + W-2])      tag_state_d = EXPECT_SOR;
        else if (wdata[i*W + W-1]) tag_state_d = IN_ROW;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_state_q <= EXPECT_SOR;
      tag_err_q   <= 1'b0;
    end else begin
      tag_state_q <= tag_state_d;
      tag_err_q   <= tag_err_d;
    end
  end

  assign tag_err = tag_err_q;
`else
  assign tag_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifmap_window_buffer.sv
module tb_ifmap_window_buffer;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int W  = DW + 2;
`ifdef IFBUF_TAG_CHECK_EN
  localparam bit TAG_EXP = 1'b1;
`else
  localparam bit TAG_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, clr, wen, rd_en, advance;
  logic [W-1:0]  wdata;
  logic          ready, rd_valid, win_valid, row_last, tag_err;
  logic [AW-1:0] stride, filter_size, rd_offset;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] sb_q[$];

  ifmap_window_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16), .PAR_IN(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .wdata(wdata), .ready(ready),
    .stride(stride), .filter_size(filter_size), .rd_en(rd_en), .rd_offset(rd_offset),
    .rd_data(rd_data), .rd_valid(rd_valid), .advance(advance), .win_valid(win_valid),
    .row_last(row_last), .count(count), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every read-data pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (sb_q.size() == 0) begin
        check("rd_unexpected", 32'(rd_data), 32'hFFFF_FFFF);
      end else begin
        check("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic sor, input logic eor, input logic [DW-1:0] d);
    wen   = 1'b1;
    wdata = {sor, eor, d};
    tick();
    wen   = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] off, input logic [DW-1:0] exp);
    rd_en     = 1'b1;
    rd_offset = off;
    sb_q.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask

  task automatic adv();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  int t1_vals [12] = '{-77, 95, -1, -54, 59, 6, -47, 15, -65, 30, -45, 54};

  initial begin
    rst = 1'b1; clr = 1'b0; wen = 1'b0; wdata = '0; rd_en = 1'b0; advance = 1'b0;
    rd_offset = '0; stride = 4'd1; filter_size = 4'd5;
    #12;
    check("rst_ready", 32'(ready), 1);
    check("rst_win_valid", 32'(win_valid), 0);
    check("rst_row_last", 32'(row_last), 0);
    check("rst_count", 32'(count), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_tag_err", 32'(tag_err), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Test 1: fill one 12-word row.
    for (int i = 0; i < 12; i++) begin
      write_word(i == 0, i == 11, 16'(t1_vals[i]));
      check("t1_count", 32'(count), 32'(i + 1));
      check("t1_win_valid", 32'(win_valid), 32'(i + 1 >= 5));
      check("t1_ready", 32'(ready), 1);
    end
    check("t1_row_last", 32'(row_last), 0);

    // Test 2: in-window read, then an out-of-window offset.
    rd(4'd2, 16'hFFFF);
    rd(4'd6, 16'h0000);
    tick();
    check("t2_rd_valid_pulse", 32'(rd_valid), 0);

    // Test 3: stride-1 advance toward the row end.
    for (int j = 0; j < 7; j++) begin
      adv();
      check("t3_count", 32'(count), 32'(11 - j));
    end
    check("t3_row_last", 32'(row_last), 1);
    check("t3_win_valid", 32'(win_valid), 1);
    rd(4'd0, 16'd15);
    adv();
    check("t3_jump_count", 32'(count), 0);
    check("t3_jump_win_valid", 32'(win_valid), 0);
    check("t3_jump_row_last", 32'(row_last), 0);
    rd_en = 1'b1; rd_offset = 4'd0;
    tick();
    rd_en = 1'b0;
    tick();
    check("t3_rd_nowin_valid", 32'(rd_valid), 0);
    check("t3_rd_nowin_hold", 32'(rd_data), 15);

    // Test 4: fill all 16 words (wr_ptr wraps), drop a beat, then free space.
    stride = 4'd2;
    for (int k = 0; k < 16; k++) begin
      write_word(1'b0, 1'b0, 16'(16'h0100 + k));
      check("t4_count", 32'(count), 32'(k + 1));
      check("t4_ready", 32'(ready), 32'(k + 1 < 16));
    end
    write_word(1'b0, 1'b0, 16'hDEAD);
    check("t4_drop_count", 32'(count), 16);
    check("t4_win_valid", 32'(win_valid), 1);
    adv();
    check("t4_adv_count", 32'(count), 14);
    check("t4_adv_ready", 32'(ready), 1);
    rd(4'd0, 16'h0102);
    rd(4'd2, 16'h0104);
    rd(4'd3, 16'h0105);
    write_word(1'b0, 1'b0, 16'h0200);
    write_word(1'b0, 1'b0, 16'h0201);
    check("t4_refill_count", 32'(count), 16);
    check("t4_refill_ready", 32'(ready), 0);

    // Test 5: write + advance + read in the same cycle.
    do_clr();
    check("clr_count", 32'(count), 0);
    check("clr_ready", 32'(ready), 1);
    check("clr_win_valid", 32'(win_valid), 0);
    for (int k = 0; k < 10; k++) write_word(1'b0, 1'b0, 16'(16'h0300 + k));
    check("t5_pre_count", 32'(count), 10);
    wen = 1'b1; wdata = {2'b00, 16'h030A};
    advance = 1'b1;
    rd_en = 1'b1; rd_offset = 4'd1; sb_q.push_back(16'h0301);
    tick();
    wen = 1'b0; advance = 1'b0; rd_en = 1'b0;
    check("t5_count", 32'(count), 9);
    rd(4'd0, 16'h0302);

    // Boundaries: filter_size 0 disables the window, stride 0 acts as 1.
    filter_size = 4'd0;
    #1;
    check("fs0_win_valid", 32'(win_valid), 0);
    rd_en = 1'b1; rd_offset = 4'd0;
    tick();
    rd_en = 1'b0;
    tick();
    check("fs0_rd_valid", 32'(rd_valid), 0);
    check("fs0_rd_hold", 32'(rd_data), 16'h0302);
    filter_size = 4'd5; stride = 4'd0;
    #1;
    check("s0_win_valid", 32'(win_valid), 1);
    adv();
    check("s0_count", 32'(count), 8);
    rd(4'd0, 16'h0303);

    // Short row: EOR inside the stride span validates a partial window.
    do_clr();
    filter_size = 4'd3; stride = 4'd4;
    write_word(1'b1, 1'b0, 16'h0011);
    write_word(1'b0, 1'b0, 16'h0022);
    check("short_win_valid_early", 32'(win_valid), 0);
    write_word(1'b0, 1'b1, 16'h0033);
    check("short_win_valid", 32'(win_valid), 1);
    check("short_row_last", 32'(row_last), 1);
    rd(4'd2, 16'h0033);
    adv();
    check("short_count", 32'(count), 0);

    // Test 6: tag checking.
    do_clr();
    write_word(1'b0, 1'b0, 16'h0042);
    check("t6_tag_err", 32'(tag_err), 32'(TAG_EXP));
    write_word(1'b1, 1'b0, 16'h0043);
    check("t6_tag_sticky", 32'(tag_err), 32'(TAG_EXP));
    do_clr();
    check("t6_tag_clr", 32'(tag_err), 0);

    tick();
    tick();
    check("sb_drained", 32'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
